ps2_rx: RTL and testbench

PS/2 device-to-host receiver that sits directly upstream of the keyboard decoder. It synchronises the raw PS/2 clock and data lines and deframes 11-bit PS/2 frames. Each frame carries a start bit, 8 data bits LSB-first, odd parity and a stop bit. Validated scan-code bytes go to the decoder over a valid/ready handshake. Receive only: the block never drives the bus, and open-drain handling stays at the top level.

---
 rtl/ps2_rx_if.sv | 22 ++
 rtl/ps2_rx.sv | 185 ++++++++++++++++++
 tb/tb_ps2_rx.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_if.sv
// ps2_rx_if: scan-code handshake and status pulses between the PS/2 receiver
// and the keyboard decoder.
interface ps2_rx_if;
    logic [7:0] code;
    logic       code_valid;
    logic       code_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    // Receiver side: produces bytes and status pulses.
    modport master (
        output code, code_valid, parity_err, frame_err, overrun,
        input  code_ready
    );

    // Decoder side: consumes bytes.
    modport slave (
        input  code, code_valid, parity_err, frame_err, overrun,
        output code_ready
    );
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver. Synchronises the raw PS/2 lines,
// deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and hands
// good bytes to the decoder over a valid/ready handshake.
// Optional macro PS2_RX_FIFO_EN: replaces the single holding register with a
// FIFO_DEPTH-entry first-word-fall-through FIFO.
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic     CLOCK_50,
    input  logic     resetn,
    input  logic     ps2_clk,
    input  logic     ps2_dat,
    ps2_rx_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_s, dat_s;
    logic          clk_d;
    logic          fe, dat;
    state_t        state, state_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [7:0]    sh, sh_n;
    logic          par_ok, par_ok_n;
    logic          push, perr_c, ferr_c;
    logic          perr_q, ferr_q;

    // Two-flop synchronisers; idle-high reset so no false edge leaves reset.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            clk_s <= 2'b11;
            dat_s <= 2'b11;
            clk_d <= 1'b1;
        end else begin
            clk_s <= {clk_s[0], ps2_clk};
            dat_s <= {dat_s[0], ps2_dat};
            clk_d <= clk_s[1];
        end
    end

    assign fe  = clk_d & ~clk_s[1];
    assign dat = dat_s[1];

    // Deframer state, shift register, counters and registered error pulses.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state  <= IDLE;
            bitcnt <= '0;
            tcnt   <= '0;
            sh     <= '0;
            par_ok <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            state  <= state_n;
            bitcnt <= bitcnt_n;
            tcnt   <= tcnt_n;
            sh     <= sh_n;
            par_ok <= par_ok_n;
            perr_q <= perr_c;
            ferr_q <= ferr_c;
        end
    end

    // Next-state logic; a timeout overrides whatever the frame state wanted.
    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        sh_n     = sh;
        par_ok_n = par_ok;
        push     = 1'b0;
        perr_c   = 1'b0;
        ferr_c   = 1'b0;
        tcnt_n   = '0;
        if (state != IDLE && !fe)
            tcnt_n = tcnt + 1'b1;

        case (state)
            IDLE: if (fe) begin
                if (!dat) begin
                    state_n  = DATA;
                    bitcnt_n = '0;
                end else begin
                    ferr_c = 1'b1;
                end
            end
            DATA: if (fe) begin
                sh_n     = {dat, sh[7:1]};
                bitcnt_n = bitcnt + 1'b1;
                if (bitcnt == 3'd7)
                    state_n = PARITY;
            end
            PARITY: if (fe) begin
                par_ok_n = ^sh ^ dat;
                state_n  = STOP;
            end
            STOP: if (fe) begin
                state_n = IDLE;
                if (!dat)
                    ferr_c = 1'b1;
                else if (par_ok)
                    push = 1'b1;
                else
                    perr_c = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        if (state != IDLE && !fe && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
            tcnt_n  = '0;
            ferr_c  = 1'b1;
        end
    end

    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;

`ifdef PS2_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wp, rp;
    logic        empty, full, pop, wr, ovr_q;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop   = !empty && bus.code_ready;
    assign wr    = push && (!full || pop);

    // FWFT FIFO; a push into a full FIFO succeeds only alongside a pop.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            wp    <= '0;
            rp    <= '0;
            ovr_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            ovr_q <= push && full && !pop;
            if (wr) begin
                mem[wp[AW-1:0]] <= sh;
                wp <= wp + 1'b1;
            end
            if (pop)
                rp <= rp + 1'b1;
        end
    end

    assign bus.code       = mem[rp[AW-1:0]];
    assign bus.code_valid = !empty;
    assign bus.overrun    = ovr_q;
`else
    logic [7:0] code_q;
    logic       vld_q, ovr_q;

    // Single holding register; a same-cycle handshake frees room for the push.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            code_q <= '0;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (push) begin
                if (vld_q && !bus.code_ready) begin
                    ovr_q <= 1'b1;
                end else begin
                    code_q <= sh;
                    vld_q  <= 1'b1;
                end
            end else if (vld_q && bus.code_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign bus.code       = code_q;
    assign bus.code_valid = vld_q;
    assign bus.overrun    = ovr_q;
`endif
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: randomized and directed frames against a frame-level model of
// the PS/2 receiver. Build with PS2_RX_FIFO_EN to exercise the FIFO variant.
module tb_ps2_rx;
    localparam int HP = 40;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_dat  = 1'b1;

    ps2_rx_if bus ();

    ps2_rx #(.TIMEOUT_CYCLES(200), .FIFO_DEPTH(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0, errors = 0;
    int cyc = 0, perr_n = 0, ferr_n = 0, ovr_n = 0, vld_n = 0, dbl_n = 0;
    int ferr_cyc = 0, fall_cyc = 0;
    int p0, f0, o0, v0, eperr, eferr;
    logic [7:0] rx_q[$], exp_q[$];
    logic [2:0] prev_p = '0;
    logic [7:0] rb;
    logic [10:0] rf;
    int kind;

    // Observe the bus mid-cycle: transfers, pulse counts, back-to-back pulses.
    always @(negedge CLOCK_50) begin
        cyc++;
        if (resetn) begin
            if (bus.code_valid) vld_n++;
            if (bus.code_valid && bus.code_ready) rx_q.push_back(bus.code);
            if (bus.parity_err) perr_n++;
            if (bus.frame_err) begin ferr_n++; ferr_cyc = cyc; end
            if (bus.overrun) ovr_n++;
            if (|(prev_p & {bus.parity_err, bus.frame_err, bus.overrun})) dbl_n++;
            prev_p = {bus.parity_err, bus.frame_err, bus.overrun};
        end else begin
            prev_p = '0;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic snap();
        p0 = perr_n; f0 = ferr_n; o0 = ovr_n; v0 = vld_n;
    endtask

    // kind 0: good frame, 1: wrong parity bit, 2: stop bit low.
    function automatic logic [10:0] build(input logic [7:0] b, input int k);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        if (k == 1) par = ~par;
        return {(k == 2) ? 1'b0 : 1'b1, par, b, 1'b0};
    endfunction

    // Model: 0 = byte delivered, 1 = parity error, 2 = framing error.
    function automatic int outcome(input logic [10:0] fr);
        if (fr[0] != 1'b0 || fr[10] != 1'b1) return 2;
        if ($countones(fr[9:1]) % 2 == 0) return 1;
        return 0;
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            cycles(HP);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            cycles(HP);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        cycles(60);
    endtask

    task automatic send(input logic [7:0] b, input int k);
        send_bits(build(b, k), 11);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, " count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk(tag, int'(rx_q[i]), int'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bus.code_ready = 1'b1;
        cycles(5);
        chk("reset code", int'(bus.code), 0);
        chk("reset valid", int'(bus.code_valid), 0);
        chk("reset pulses", int'({bus.parity_err, bus.frame_err, bus.overrun}), 0);
        resetn = 1'b1;
        cycles(5);

        // Plain 0x1C frame.
        snap();
        send(8'h1C, 0);
        exp_q.push_back(8'h1C);
        check_rx("t1 byte");
        chk("t1 valid cycles", vld_n - v0, 1);
        chk("t1 perr", perr_n - p0, 0);
        chk("t1 ferr", ferr_n - f0, 0);

        // Bad parity, then a good 0xF0.
        snap();
        send(8'h1C, 1);
        chk("t2 perr", perr_n - p0, 1);
        chk("t2 valid cycles", vld_n - v0, 0);
        send(8'hF0, 0);
        exp_q.push_back(8'hF0);
        check_rx("t2 byte");

        // Truncated frame times out, then a good 0x5A.
        snap();
        send_bits(build(8'h05, 0), 4);
        cycles(200);
        chk("t3 ferr", ferr_n - f0, 1);
        chk("t3 timeout delay ok", int'(ferr_cyc - fall_cyc >= 195 && ferr_cyc - fall_cyc <= 215), 1);
        chk("t3 no byte", rx_q.size(), 0);
        send(8'h5A, 0);
        exp_q.push_back(8'h5A);
        check_rx("t3 byte");

        // Stop bit low on 0x1C.
        snap();
        send(8'h1C, 2);
        chk("t4 ferr", ferr_n - f0, 1);
        chk("t4 perr", perr_n - p0, 0);
        chk("t4 no byte", rx_q.size(), 0);

        // Random frames against the frame-level model.
        snap();
        eperr = 0; eferr = 0;
        repeat (12) begin
            rb   = 8'($urandom);
            kind = $urandom_range(0, 9);
            kind = (kind < 7) ? 0 : (kind < 9) ? 1 : 2;
            rf   = build(rb, kind);
            case (outcome(rf))
                0:       exp_q.push_back(rb);
                1:       eperr++;
                default: eferr++;
            endcase
            send_bits(rf, 11);
        end
        check_rx("rand byte");
        chk("rand perr", perr_n - p0, eperr);
        chk("rand ferr", ferr_n - f0, eferr);
        chk("rand ovr", ovr_n - o0, 0);

`ifndef PS2_RX_FIFO_EN
        // Holding register full: second byte overruns.
        bus.code_ready = 1'b0;
        snap();
        send(8'h1C, 0);
        send(8'h32, 0);
        chk("t5 held code", int'(bus.code), 8'h1C);
        chk("t5 held valid", int'(bus.code_valid), 1);
        chk("t5 ovr", ovr_n - o0, 1);
        chk("t5 no transfer", rx_q.size(), 0);
        bus.code_ready = 1'b1;
        cycles(3);
        chk("t5 valid drop", int'(bus.code_valid), 0);
        exp_q.push_back(8'h1C);
        check_rx("t5 byte");
`else
        // FIFO fills at four; fifth byte overruns; drain in order.
        bus.code_ready = 1'b0;
        snap();
        for (int k = 1; k <= 4; k++) send(8'(k), 0);
        chk("t6 ovr before fifth", ovr_n - o0, 0);
        chk("t6 head", int'(bus.code), 1);
        send(8'h05, 0);
        chk("t6 ovr", ovr_n - o0, 1);
        bus.code_ready = 1'b1;
        cycles(10);
        for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
        check_rx("t6 drain");
        chk("t6 empty", int'(bus.code_valid), 0);
`endif

        // Reset mid-frame with a byte pending: everything cleared, no pulse.
        bus.code_ready = 1'b0;
        send(8'hA5, 0);
        chk("rst pending valid", int'(bus.code_valid), 1);
        send_bits(build(8'h3C, 0), 5);
        resetn = 1'b0;
        cycles(2);
        snap();
        chk("rst valid", int'(bus.code_valid), 0);
        chk("rst code", int'(bus.code), 0);
        resetn = 1'b1;
        cycles(300);
        chk("rst ferr", ferr_n - f0, 0);
        chk("rst perr", perr_n - p0, 0);
        chk("rst valid after", int'(bus.code_valid), 0);
        bus.code_ready = 1'b1;
        send(8'h77, 0);
        exp_q.push_back(8'h77);
        rx_q.delete();
        send(8'h78, 0);
        exp_q.delete();
        exp_q.push_back(8'h78);
        check_rx("rst recover");

        chk("single-cycle pulses", dbl_n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
